// File: rtl/alu_arb_pkg.sv
// Shared types for the two-requester ALU arbiter: opcodes, FSM states and
// the round-robin winner selection.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // A lone requester always wins; the pointer only breaks ties.
  function automatic logic pick_winner(input logic [1:0] valid, input logic ptr);
    return (valid == 2'b11) ? ptr : valid[1];
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 4-bit ALU; results are the plain 4-bit modulo values.
module alu_arbiter_alu
  import alu_arb_pkg::*;
(
  output logic [3:0] C,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [1:0] Op
);

  always_comb begin
    C = 4'd0;
    case (Op)
      OP_ADD: C = A + B;
      OP_SUB: C = A - B;
      OP_MUL: C = A * B;
      OP_DIV: C = (B == 4'd0) ? 4'd0 : A / B;
      default: C = 4'd0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that serves two requesters through one shared ALU,
// one operation at a time, with a registered valid/ready response.
//
//   state   | meaning
//   IDLE    | waiting for a request; grant and latch operands in the same cycle
//   EXEC    | latched operands drive the ALU; result is registered
//   RESP    | response presented until the consumer accepts it
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter logic [3:0] DIV0_RESULT = 4'hF,
  parameter int         CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [3:0]       req_a0,
  input  logic [3:0]       req_b0,
  input  logic [3:0]       req_a1,
  input  logic [3:0]       req_b1,
  input  logic [1:0]       req_op0,
  input  logic [1:0]       req_op1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [3:0]       rsp_c,
  output logic             rsp_div0,
  output logic [CNT_W-1:0] op_count
);

  state_e           state_q;
  logic             ptr_q;
  logic             owner_q;
  logic [3:0]       a_q, b_q;
  op_e              op_q;
  logic             rsp_valid_q;
  logic [3:0]       rsp_c_q;
  logic             rsp_div0_q;
  logic [CNT_W-1:0] op_count_q;

  logic             winner;
  logic             grant;
  logic [3:0]       a_d, b_d;
  op_e              op_d;
  logic [3:0]       alu_c;
  logic             div0;
  logic [3:0]       rsp_c_d;
  logic [CNT_W-1:0] op_count_d;

  // rst_n gates the grant so no requester sees ready while reset is held.
  assign winner    = pick_winner(req_valid, ptr_q);
  assign grant     = rst_n && (state_q == ST_IDLE) && (req_valid != 2'b00);
  assign req_ready = grant ? (winner ? 2'b10 : 2'b01) : 2'b00;

  assign a_d  = winner ? req_a1 : req_a0;
  assign b_d  = winner ? req_b1 : req_b0;
  assign op_d = op_e'(winner ? req_op1 : req_op0);

  alu_arbiter_alu u_alu (
    .C  (alu_c),
    .A  (a_q),
    .B  (b_q),
    .Op (op_q)
  );

  assign div0       = (op_q == OP_DIV) && (b_q == 4'd0);
  assign rsp_c_d    = div0 ? DIV0_RESULT : alu_c;
  assign op_count_d = op_count_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      a_q         <= 4'd0;
      b_q         <= 4'd0;
      op_q        <= OP_ADD;
      rsp_valid_q <= 1'b0;
      rsp_c_q     <= 4'd0;
      rsp_div0_q  <= 1'b0;
      op_count_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            owner_q <= winner;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_c_q     <= rsp_c_d;
          rsp_div0_q  <= div0;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count_q  <= op_count_d;
            ptr_q       <= ~owner_q;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = owner_q;
  assign rsp_c     = rsp_c_q;
  assign rsp_div0  = rsp_div0_q;
  assign op_count  = op_count_q;

endmodule
